// File: rtl/floor_request_queue_if.sv
// Request/status bundle between the car input panel, the motion controller and the
// floor request queue. The master side drives requests and pops; the slave side is the queue.
interface floor_request_queue_if #(
    parameter int unsigned NUM_FLOORS = 7,
    parameter int unsigned FLOOR_W    = 3
);
    logic                  r_nwr;
    logic [FLOOR_W-1:0]    requested_floor;
    logic                  clear;
    logic                  pop;
    logic [FLOOR_W-1:0]    next_floor;
    logic                  next_valid;
    logic [NUM_FLOORS-1:0] queue_status;
    logic [FLOOR_W-1:0]    count;
    logic                  full;

    modport master (
        output r_nwr, requested_floor, clear, pop,
        input  next_floor, next_valid, queue_status, count, full
    );

    modport slave (
        input  r_nwr, requested_floor, clear, pop,
        output next_floor, next_valid, queue_status, count, full
    );
endinterface

// File: rtl/floor_request_queue.sv
// In-car floor request queue: deduplicating circular FIFO of pending floors with a
// per-floor membership bitmap that also drives the button lamps.
module floor_request_queue #(
    parameter int unsigned NUM_FLOORS = 7,
    parameter int unsigned FLOOR_W    = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    floor_request_queue_if.slave          bus
);

    localparam logic [FLOOR_W-1:0]    LAST_PTR  = FLOOR_W'(NUM_FLOORS - 1);
    localparam logic [FLOOR_W:0]      NF_WIDE   = (FLOOR_W + 1)'(NUM_FLOORS);
    localparam logic [FLOOR_W-1:0]    FULL_CNT  = FLOOR_W'(NUM_FLOORS);
    localparam logic [NUM_FLOORS-1:0] ONE_BIT   = {{(NUM_FLOORS - 1){1'b0}}, 1'b1};

    logic [FLOOR_W-1:0]    mem [NUM_FLOORS];
    logic [FLOOR_W-1:0]    head_q, head_d;
    logic [FLOOR_W-1:0]    tail_q, tail_d;
    logic [FLOOR_W-1:0]    count_q, count_d;
    logic [NUM_FLOORS-1:0] status_q, status_d;

    logic                  empty;
    logic                  pop_fire;
    logic                  in_range;
    logic                  wr_en;
    logic [NUM_FLOORS-1:0] head_bit;
    logic [NUM_FLOORS-1:0] req_bit;
    logic [NUM_FLOORS-1:0] status_after_pop;

    function automatic logic [FLOOR_W-1:0] ptr_inc(input logic [FLOOR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + FLOOR_W'(1);
    endfunction

    assign empty    = (count_q == '0);
    assign head_bit = ONE_BIT << mem[head_q];
    assign req_bit  = ONE_BIT << bus.requested_floor;

    // Next-state: clear wins, then pop, then write judged against the post-pop membership.
    always_comb begin
        head_d           = head_q;
        tail_d           = tail_q;
        count_d          = count_q;
        status_d         = status_q;
        wr_en            = 1'b0;
        pop_fire         = bus.pop && !empty;
        in_range         = ({1'b0, bus.requested_floor} < NF_WIDE);
        status_after_pop = pop_fire ? (status_q & ~head_bit) : status_q;

        if (bus.clear) begin
            head_d   = '0;
            tail_d   = '0;
            count_d  = '0;
            status_d = '0;
        end else begin
            // A re-request of the floor being popped is accepted since its bit is already gone.
            wr_en    = !bus.r_nwr && in_range && ((status_after_pop & req_bit) == '0);
            status_d = status_after_pop;
            if (pop_fire) begin
                head_d = ptr_inc(head_q);
            end
            if (wr_en) begin
                tail_d   = ptr_inc(tail_q);
                status_d = status_after_pop | req_bit;
            end
            unique case ({wr_en, pop_fire})
                2'b10:   count_d = count_q + FLOOR_W'(1);
                2'b01:   count_d = count_q - FLOOR_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers with asynchronous flush on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            status_q <= '0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            status_q <= status_d;
        end
    end

    // Entry storage; only the tail slot is written when a request is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_FLOORS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[tail_q] <= bus.requested_floor;
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        bus.next_floor   = empty ? '0 : mem[head_q];
        bus.next_valid   = !empty;
        bus.queue_status = status_q;
        bus.count        = count_q;
        bus.full         = (count_q == FULL_CNT);
    end

endmodule

// File: doc/floor_request_queue.md
# floor_request_queue

In-car floor request queue: the receiving end of the car input panel's request interface. Accepts write strobes (`r_nwr` low) carrying a 3-bit floor number, discards duplicates and out-of-range floors, and stores pending floors in arrival order. Drives the per-floor button lamps (`queue_status`) and presents the oldest pending floor to the car motion controller, which pops it on arrival.

## Interface
- `NUM_FLOORS`, 7: floors served, numbered 0..NUM_FLOORS-1; also the queue depth.
- `FLOOR_W`, 3: floor number width.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `r_nwr`  in  1  request strobe from the input panel; 0 = write request this cycle, 1 = idle.
- `requested_floor`  in  FLOOR_W  floor number; valid when `r_nwr` = 0.
- `clear`  in  1  synchronous flush of all pending requests (e.g. fire service).
- `pop`  in  1  controller has serviced the head floor; one-cycle pulse.
- `next_floor`  out  FLOOR_W  oldest pending floor; 0 when empty.
- `next_valid`  out  1  queue not empty.
- `queue_status`  out  NUM_FLOORS  bit f set while floor f is pending (button lamp drive).
- `count`  out  FLOOR_W  number of pending entries, 0..NUM_FLOORS.
- `full`  out  1  `count` == NUM_FLOORS.

## Operation
- Storage: NUM_FLOORS-entry circular FIFO of floor numbers, head/tail pointers wrapping at NUM_FLOORS-1 -> 0, plus `queue_status` bitmap as the membership set.
- Write accepted when `r_nwr` = 0, `requested_floor` < NUM_FLOORS, and the floor's `queue_status` bit is clear after any same-cycle pop; accepted floor goes to tail, bit set, `count` +1.
- Ignored writes (no state change): floor >= NUM_FLOORS (3'b111), floor already pending. A button held for many cycles therefore yields exactly one entry.
- Dedupe guarantees at most NUM_FLOORS entries; a write while `full` is always a duplicate, so overflow is impossible.
- Pop: when `pop` = 1 and `next_valid` = 1, head entry removed, its `queue_status` bit cleared, `count` -1. `pop` while empty is ignored.
- Simultaneous pop and write: pop applied first, then the write evaluated. A write of the floor being popped is accepted and appended at tail (re-request). `count` unchanged for pop+accepted write.
- `clear` = 1: all entries, pointers, `count`, `queue_status` zeroed; same-cycle `pop` and write are ignored.
- Priority: `reset` > `clear` > pop > write.

## Timing
- All outputs registered or decoded from registered state only; no combinational path from `r_nwr`, `requested_floor`, `pop`, `clear` to any output.
- Reset values: `next_floor` 0, `next_valid` 0, `queue_status` 0, `count` 0, `full` 0; pointers 0. Reset asserted mid-operation discards all entries immediately (asynchronous).
- Write sampled at edge N -> `queue_status` bit, `count`, `full` updated after edge N; if queue was empty, `next_floor`/`next_valid` also valid after edge N (1-cycle latency).
- Pop at edge N -> new head on `next_floor` after edge N; `next_valid` falls after edge N if last entry popped.
- Controller may issue back-to-back `pop` pulses; one entry removed per cycle.
- Panel may issue back-to-back writes of different floors; one accepted per cycle.

## Test plan
- Reset: assert `reset` mid-cycle with 3 entries pending -> all outputs 0 immediately; after release, `next_valid` 0, `queue_status` 7'h00.
- Ordering: write 3, 1, 5 on consecutive cycles -> `queue_status` 7'h2A, `count` 3, `next_floor` 3; pop x3 -> `next_floor` 1, 5, then `next_valid` 0, `queue_status` 7'h00.
- Held button: `r_nwr` = 0, floor 4 for 10 cycles -> `count` 1, `queue_status` 7'h10; invalid floor 7 written -> no change.
- Full/wrap: write 0..6 -> `full` 1, `count` 7, `queue_status` 7'h7F; pop 2, write 0 -> tail wraps, pop order 2,3,4,5,6,0.
- Simultaneous: queue {2,6}, same cycle `pop` + write 2 -> queue {6,2}, `count` 2; `pop` while empty -> no change.
- Clear: queue {1,4,5}, `clear` with `pop` and write 3 same cycle -> `count` 0, `queue_status` 7'h00, `next_valid` 0.
